mdu_sequencer: RTL

- Iterative multiply/divide controller feeding the EX stage. One operation at a time.
- Sequences a radix-2 shift-add multiplier and a restoring divider, then drives the HI/LO result registers.
- Its busy output is the pipeline's mult_div_stall; its done pulse is cal_finish, consumed by flow_control.
- Sits beside the ALU in execute. Operands come from the ID/EX ALUa/ALUb registers.

---
 rtl/mdu_if.sv | 25 ++
 rtl/mdu_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// Handshake/result bundle between the execute stage and the multiply/divide sequencer.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (
    output start, op, cancel, a, b,
    input  busy, done, hi, lo, div0
  );

  modport slave (
    input  start, op, cancel, a, b,
    output busy, done, hi, lo, div0
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative radix-2 multiply / restoring divide sequencer driving HI/LO.
// Optional macro MDU_EARLY_OUT_EN: multiplies leave CALC once the multiplier runs out of set bits.
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, done_q, div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic               ld_res;

  // Datapath registers: op code, operand signs, the fixed operand and the {hi,lo} work pair.
  logic [1:0]         op_q;
  logic               sa_q, sb_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] pair_q;

  logic               accept, start_div0, in_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_prod, mul_res;
  logic [WIDTH:0]     rem_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_diff, quo_res, rem_res;
  logic               calc_exit;

  assign in_signed  = ~bus.op[0];
  assign a_abs      = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs      = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign accept     = (state_q == IDLE || state_q == DONE) && bus.start && !bus.cancel;
  assign start_div0 = accept && bus.op[1] && (bus.b == '0);

  // Shift-add step: the carry out of the add becomes the new MSB of the shifted pair.
  assign mul_sum  = {1'b0, pair_q[2*WIDTH-1:WIDTH]} + (pair_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, pair_q[WIDTH-1:1]};

  // Restoring step: the shifted remainder needs one extra bit before the trial subtract.
  assign rem_shift = {pair_q[2*WIDTH-1:WIDTH], pair_q[WIDTH-1]};
  assign div_ok    = rem_shift >= {1'b0, opnd_q};
  assign div_diff  = rem_shift[WIDTH-1:0] - opnd_q;
  assign div_next  = {div_ok ? div_diff : rem_shift[WIDTH-1:0], pair_q[WIDTH-2:0], div_ok};

`ifdef MDU_EARLY_OUT_EN
  logic [WIDTH-1:0] mrem_q;
  logic [CNT_W-1:0] align_sh;

  // Remaining multiplier bits; once this shifts to zero no further add can happen.
  always_ff @(posedge clk) begin
    if (accept)                mrem_q <= b_abs;
    else if (state_q == CALC)  mrem_q <= mrem_q >> 1;
  end

  assign calc_exit = (cnt_q == CNT_W'(WIDTH - 1)) ||
                     (!op_q[1] && (mrem_q[WIDTH-1:1] == '0));
  assign align_sh  = CNT_W'(WIDTH) - cnt_q;
  assign mul_prod  = pair_q >> align_sh;
`else
  assign calc_exit = (cnt_q == CNT_W'(WIDTH - 1));
  assign mul_prod  = pair_q;
`endif

  assign mul_res = (!op_q[0] && (sa_q ^ sb_q)) ? -mul_prod : mul_prod;
  assign quo_res = (!op_q[0] && (sa_q ^ sb_q)) ? -pair_q[WIDTH-1:0] : pair_q[WIDTH-1:0];
  assign rem_res = (!op_q[0] && sa_q) ? -pair_q[2*WIDTH-1:WIDTH] : pair_q[2*WIDTH-1:WIDTH];

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div0_d  = div0_q;
    ld_res  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          cnt_d  = '0;
          div0_d = start_div0;
          if (start_div0) begin
            state_d = DONE;
            ld_res  = 1'b1;
            hi_d    = bus.a;
            lo_d    = '1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (calc_exit) state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          ld_res  = 1'b1;
          if (op_q[1]) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            hi_d = mul_res[2*WIDTH-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode so they line up with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CALC) || (state_d == FIXUP);
      done_q  <= (state_d == DONE);
      div0_q  <= div0_d;
      if (ld_res) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  // NOTE: only control state is reset; these registers are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= bus.op;
      sa_q <= in_signed & bus.a[WIDTH-1];
      sb_q <= in_signed & bus.b[WIDTH-1];
      if (bus.op[1]) begin
        opnd_q <= b_abs;
        pair_q <= {{WIDTH{1'b0}}, a_abs};
      end else begin
        opnd_q <= a_abs;
        pair_q <= {{WIDTH{1'b0}}, b_abs};
      end
    end else if (state_q == CALC) begin
      pair_q <= op_q[1] ? div_next : mul_next;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
